// File: rtl/mips_controller.sv
// mips_controller: multi-cycle control FSM driving the MIPS datapath selects and enables.
// Define CTRL_BNE_EN to add the BNE branch state (BNEEX=11).
module mips_controller #(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       PCEn,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       branch,
  output logic       PCSrc,
  output logic [2:0] ALUControl,
  output logic [1:0] ALUSrcB,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BEQEX  = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_BNEEX  = 4'd11
  } state_t;

  localparam logic [3:0] LP_WAIT = MEM_WAIT[3:0];
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
`ifdef CTRL_BNE_EN
  localparam logic [5:0] OP_BNE  = 6'b000101;
`endif

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_cnt;
  logic       w_cnt_done;
  logic [2:0] w_rfn;
  logic       w_irw;
  logic       w_pcw;
  logic       w_memw;
  logic       w_regw;
  logic       w_bne;

  assign w_cnt_done = (r_cnt == LP_WAIT);
  assign state      = r_state;

  // Counter only advances while a memory wait state is held; saturates at LP_WAIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) begin
        r_cnt <= '0;
      end else if (!w_cnt_done) begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

  always_comb begin
    w_next = S_FETCH;
    unique case (r_state)
      S_FETCH:  w_next = w_cnt_done ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXEC;
          OP_BEQ:       w_next = S_BEQEX;
          OP_ADDI:      w_next = S_ADDIEX;
`ifdef CTRL_BNE_EN
          OP_BNE:       w_next = S_BNEEX;
`endif
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR: w_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  w_next = w_cnt_done ? S_MEMWB : S_MEMRD;
      S_EXEC:   w_next = S_ALUWB;
      S_ADDIEX: w_next = S_ADDIWB;
      default:  w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_rfn = ALU_ADD;
    case (funct)
      6'b100000: w_rfn = ALU_ADD;
      6'b100010: w_rfn = ALU_SUB;
      6'b100100: w_rfn = 3'b000;
      6'b100101: w_rfn = 3'b001;
      6'b101010: w_rfn = 3'b111;
      default:   w_rfn = ALU_ADD;
    endcase
  end

  always_comb begin
    IorD       = 1'b0;
    MemtoReg   = 1'b0;
    RegDst     = 1'b0;
    branch     = 1'b0;
    PCSrc      = 1'b0;
    ALUControl = 3'b000;
    ALUSrcB    = 2'b00;
    ALUSrcA    = 1'b0;
    w_irw      = 1'b0;
    w_pcw      = 1'b0;
    w_memw     = 1'b0;
    w_regw     = 1'b0;
    w_bne      = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        ALUSrcB    = 2'b01;
        ALUControl = ALU_ADD;
        w_irw      = w_cnt_done;
        w_pcw      = w_cnt_done;
      end
      S_DECODE: begin
        ALUSrcB    = 2'b11;
        ALUControl = ALU_ADD;
      end
      S_MEMADR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ALUControl = ALU_ADD;
      end
      S_MEMRD:  IorD = 1'b1;
      S_MEMWB: begin
        MemtoReg = 1'b1;
        w_regw   = 1'b1;
      end
      S_MEMWR: begin
        IorD   = 1'b1;
        w_memw = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA    = 1'b1;
        ALUControl = w_rfn;
      end
      S_ALUWB: begin
        RegDst = 1'b1;
        w_regw = 1'b1;
      end
      S_BEQEX: begin
        ALUSrcA    = 1'b1;
        ALUControl = ALU_SUB;
        PCSrc      = 1'b1;
        branch     = 1'b1;
      end
      S_ADDIEX: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ALUControl = ALU_ADD;
      end
      S_ADDIWB: w_regw = 1'b1;
`ifdef CTRL_BNE_EN
      S_BNEEX: begin
        ALUSrcA    = 1'b1;
        ALUControl = ALU_SUB;
        PCSrc      = 1'b1;
        branch     = 1'b1;
        w_bne      = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Write enables are held off for the whole time reset is asserted.
  assign IRWrite  = reset & w_irw;
  assign PCWrite  = reset & w_pcw;
  assign MemWrite = reset & w_memw;
  assign RegWrite = reset & w_regw;
  assign PCEn     = reset & (w_pcw | (w_bne ? ~zero : (branch & zero)));

endmodule
